// File: rtl/ts_pkg.sv
// Shared types and defaults for the TSN egress transmit scheduler.
package ts_pkg;

   localparam int TS_NQ_DEF      = 8;
   localparam int TS_MD_W_DEF    = 8;
   localparam int TS_TIMEOUT_DEF = 15;
   localparam int TS_STAT_W      = 16;

   typedef enum logic {IDLE, WAIT_MD} ts_state_e;

   // Bits needed to index n items (minimum 1).
   function automatic int ts_log2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/ts_arb.sv
// Combinational queue picker: lowest eligible index at or after a start point.
module ts_arb #(
   parameter int NQ = 8,
   parameter int QW = 3
) (
   input  logic [NQ-1:0] elig,
   input  logic [QW-1:0] rr_ptr,
   input  logic          mode,
   output logic [QW-1:0] winner,
   output logic          any_valid
);

   int start;
   int idx;

   // Strict priority is round-robin with the search anchored at queue 0.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      idx       = 0;
      start     = mode ? int'(rr_ptr) : 0;
      for (int i = 0; i < NQ; i++) begin
         idx = start + i;
         if (idx >= NQ) idx = idx - NQ;
         if (!any_valid && elig[idx]) begin
            any_valid = 1'b1;
            winner    = QW'(idx);
         end
      end
   end

endmodule

// File: rtl/ts_sched.sv
// TSN egress transmit scheduler: one outstanding MB read with bounded wait.
// Define TS_SCHED_STAT_EN to add per-queue forwarded and timeout counters.
module ts_sched
   import ts_pkg::*;
#(
   parameter int NQ         = TS_NQ_DEF,
   parameter int MD_W       = TS_MD_W_DEF,
   parameter int RR_MODE    = 0,
   parameter int MD_TIMEOUT = TS_TIMEOUT_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NQ-1:0]          in_ts_gate_open,
   input  logic [NQ-1:0]          in_ts_q_empty,
   input  logic                   in_ts_ebm_ready,
   output logic [NQ-1:0]          out_ts_q_rden,
   input  logic [MD_W-1:0]        in_ts_md,
   input  logic                   in_ts_md_wr,
   output logic [MD_W-1:0]        out_ts_md,
   output logic [ts_log2(NQ)-1:0] out_ts_md_qid,
   output logic                   out_ts_md_wr,
   output logic                   out_ts_timeout
`ifdef TS_SCHED_STAT_EN
  ,output logic [NQ*TS_STAT_W-1:0] out_ts_stat_cnt,
   output logic [TS_STAT_W-1:0]    out_ts_timeout_cnt
`endif
);

   localparam int QW = ts_log2(NQ);

   ts_state_e       state_q, state_d;
   logic [QW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [QW-1:0]   qid_q, qid_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [NQ-1:0]   rden_q, rden_d;
   logic [MD_W-1:0] md_q, md_d;
   logic [QW-1:0]   md_qid_q, md_qid_d;
   logic            md_wr_q, md_wr_d;
   logic            timeout_q, timeout_d;

   logic [NQ-1:0]   elig;
   logic [QW-1:0]   winner;
   logic            any_valid;

   assign elig = in_ts_gate_open & ~in_ts_q_empty & {NQ{in_ts_ebm_ready}};

   ts_arb #(.NQ(NQ), .QW(QW)) u_arb (
      .elig      (elig),
      .rr_ptr    (rr_ptr_q),
      .mode      (RR_MODE != 0),
      .winner    (winner),
      .any_valid (any_valid)
   );

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      qid_d     = qid_q;
      cnt_d     = cnt_q;
      rden_d    = '0;
      md_d      = '0;
      md_qid_d  = '0;
      md_wr_d   = 1'b0;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_valid) begin
               rden_d  = NQ'(1) << winner;
               qid_d   = winner;
               cnt_d   = '0;
               state_d = WAIT_MD;
               if (RR_MODE != 0)
                  rr_ptr_d = (winner == QW'(NQ - 1)) ? '0 : winner + 1'b1;
            end
         end
         WAIT_MD: begin
            cnt_d = cnt_q + 1'b1;
            // A late md in the expiry cycle still wins over the timeout.
            if (in_ts_md_wr) begin
               md_d     = in_ts_md;
               md_qid_d = qid_q;
               md_wr_d  = 1'b1;
               state_d  = IDLE;
            end else if (cnt_q == 8'(MD_TIMEOUT - 1)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         qid_q     <= '0;
         cnt_q     <= '0;
         rden_q    <= '0;
         md_q      <= '0;
         md_qid_q  <= '0;
         md_wr_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         qid_q     <= qid_d;
         cnt_q     <= cnt_d;
         rden_q    <= rden_d;
         md_q      <= md_d;
         md_qid_q  <= md_qid_d;
         md_wr_q   <= md_wr_d;
         timeout_q <= timeout_d;
      end
   end

   assign out_ts_q_rden  = rden_q;
   assign out_ts_md      = md_q;
   assign out_ts_md_qid  = md_qid_q;
   assign out_ts_md_wr   = md_wr_q;
   assign out_ts_timeout = timeout_q;

`ifdef TS_SCHED_STAT_EN
   logic [NQ-1:0][TS_STAT_W-1:0] stat_q, stat_d;
   logic [TS_STAT_W-1:0]         tocnt_q, tocnt_d;

   // Counters advance in the same edge that raises the matching output pulse.
   always_comb begin
      for (int i = 0; i < NQ; i++) begin
         stat_d[i] = stat_q[i];
         if (md_wr_d && md_qid_d == QW'(i) && stat_q[i] != '1)
            stat_d[i] = stat_q[i] + 1'b1;
      end
      tocnt_d = tocnt_q;
      if (timeout_d && tocnt_q != '1) tocnt_d = tocnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_q  <= '0;
         tocnt_q <= '0;
      end else begin
         stat_q  <= stat_d;
         tocnt_q <= tocnt_d;
      end
   end

   assign out_ts_stat_cnt    = stat_q;
   assign out_ts_timeout_cnt = tocnt_q;
`endif

endmodule

// File: tb/tb_ts_sched.sv
// Directed bench for ts_sched: a strict-priority and a round-robin instance share stimulus.
module tb_ts_sched;

   localparam int NQ = 4;
   localparam int MD_W = 8;
   localparam int QW = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NQ-1:0]   gate = '0;
   logic [NQ-1:0]   empty = '1;
   logic            ready = 1'b0;
   logic [MD_W-1:0] md_in = '0;
   logic            md_wr = 1'b0;

   logic [NQ-1:0]   sp_rden, rr_rden;
   logic [MD_W-1:0] sp_md, rr_md;
   logic [QW-1:0]   sp_qid, rr_qid;
   logic            sp_wr, rr_wr, sp_to, rr_to;
`ifdef TS_SCHED_STAT_EN
   logic [NQ*16-1:0] sp_stat, rr_stat;
   logic [15:0]      sp_tocnt, rr_tocnt;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ts_sched #(.NQ(NQ), .MD_W(MD_W), .RR_MODE(0), .MD_TIMEOUT(15)) u_sp (
      .clk(clk), .rst_n(rst_n), .in_ts_gate_open(gate), .in_ts_q_empty(empty),
      .in_ts_ebm_ready(ready), .out_ts_q_rden(sp_rden), .in_ts_md(md_in),
      .in_ts_md_wr(md_wr), .out_ts_md(sp_md), .out_ts_md_qid(sp_qid),
      .out_ts_md_wr(sp_wr), .out_ts_timeout(sp_to)
`ifdef TS_SCHED_STAT_EN
     ,.out_ts_stat_cnt(sp_stat), .out_ts_timeout_cnt(sp_tocnt)
`endif
   );

   ts_sched #(.NQ(NQ), .MD_W(MD_W), .RR_MODE(1), .MD_TIMEOUT(15)) u_rr (
      .clk(clk), .rst_n(rst_n), .in_ts_gate_open(gate), .in_ts_q_empty(empty),
      .in_ts_ebm_ready(ready), .out_ts_q_rden(rr_rden), .in_ts_md(md_in),
      .in_ts_md_wr(md_wr), .out_ts_md(rr_md), .out_ts_md_qid(rr_qid),
      .out_ts_md_wr(rr_wr), .out_ts_timeout(rr_to)
`ifdef TS_SCHED_STAT_EN
     ,.out_ts_stat_cnt(rr_stat), .out_ts_timeout_cnt(rr_tocnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, " sp_rden"}, 64'(sp_rden), 64'h0);
      chk({tag, " rr_rden"}, 64'(rr_rden), 64'h0);
      chk({tag, " sp_wr"}, 64'(sp_wr), 64'h0);
      chk({tag, " sp_md"}, 64'(sp_md), 64'h0);
      chk({tag, " sp_qid"}, 64'(sp_qid), 64'h0);
      chk({tag, " rr_wr"}, 64'(rr_wr), 64'h0);
      chk({tag, " sp_to"}, 64'(sp_to), 64'h0);
      chk({tag, " rr_to"}, 64'(rr_to), 64'h0);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Grant, MB answers two cycles after rden, forward; ends with the forward visible.
   task automatic do_txn(input string tag, input logic [7:0] md, input logic [3:0] e_sp,
                         input logic [3:0] e_rr, input logic [1:0] q_sp, input logic [1:0] q_rr);
      tick();
      chk({tag, " sp_rden"}, 64'(sp_rden), 64'(e_sp));
      chk({tag, " rr_rden"}, 64'(rr_rden), 64'(e_rr));
      tick();
      chk({tag, " gap1 rden"}, 64'({sp_rden, rr_rden}), 64'h0);
      tick();
      chk({tag, " gap2 rden"}, 64'({sp_rden, rr_rden}), 64'h0);
      chk({tag, " pre wr/md"}, 64'({sp_wr, sp_md}), 64'h0);
      md_wr = 1'b1;
      md_in = md;
      tick();
      md_wr = 1'b0;
      md_in = '0;
      chk({tag, " sp_wr"}, 64'(sp_wr), 64'h1);
      chk({tag, " sp_md"}, 64'(sp_md), 64'(md));
      chk({tag, " sp_qid"}, 64'(sp_qid), 64'(q_sp));
      chk({tag, " rr_wr"}, 64'(rr_wr), 64'h1);
      chk({tag, " rr_qid"}, 64'(rr_qid), 64'(q_rr));
      chk({tag, " rden gap3"}, 64'({sp_rden, rr_rden}), 64'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      chk_idle_outs("reset");
      rst_n = 1'b1;

      // Strict priority: queue 0 empty, so queue 1 keeps winning in SP.
      gate = 4'b1111; empty = 4'b0001; ready = 1'b1;
      do_txn("sp1", 8'hA5, 4'b0010, 4'b0010, 2'd1, 2'd1);
      do_txn("sp2", 8'h3C, 4'b0010, 4'b0100, 2'd1, 2'd2);
`ifdef TS_SCHED_STAT_EN
      chk("sp stat", 64'(sp_stat), 64'h0000_0000_0002_0000);
      chk("rr stat", 64'(rr_stat), 64'h0000_0001_0001_0000);
`endif

      // Round-robin from a fresh pointer, all queues eligible.
      pulse_reset();
      empty = 4'b0000;
      do_txn("rr0", 8'h11, 4'b0001, 4'b0001, 2'd0, 2'd0);
      do_txn("rr1", 8'h22, 4'b0001, 4'b0010, 2'd0, 2'd1);
      do_txn("rr2", 8'h33, 4'b0001, 4'b0100, 2'd0, 2'd2);
      do_txn("rr3", 8'h44, 4'b0001, 4'b1000, 2'd0, 2'd3);
      do_txn("rr4", 8'h55, 4'b0001, 4'b0001, 2'd0, 2'd0);

      // Gating: only queue 2 open; gate closes right after rden.
      gate = 4'b0100; empty = 4'b1010;
      tick();
      chk("gate sp_rden", 64'(sp_rden), 64'h4);
      chk("gate rr_rden", 64'(rr_rden), 64'h4);
      gate = 4'b0000;
      tick();
      tick();
      md_wr = 1'b1; md_in = 8'h5A;
      tick();
      md_wr = 1'b0; md_in = '0;
      chk("gate sp_wr", 64'(sp_wr), 64'h1);
      chk("gate sp_qid", 64'(sp_qid), 64'h2);
      chk("gate rr_qid", 64'(rr_qid), 64'h2);
      chk("gate sp_md", 64'(sp_md), 64'h5A);
      tick();
      chk("gate closed rden", 64'({sp_rden, rr_rden}), 64'h0);

      // md_wr while idle is dropped.
      md_wr = 1'b1; md_in = 8'h77;
      tick();
      md_wr = 1'b0; md_in = '0;
      chk("idle md_wr sp", 64'({sp_wr, sp_md}), 64'h0);
      chk("idle md_wr rr", 64'({rr_wr, rr_md}), 64'h0);

      // Backpressure: no grants, rr pointer held at 3.
      gate = 4'b1111; empty = 4'b0000; ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp rden", 64'({sp_rden, rr_rden}), 64'h0);
      end
      ready = 1'b1;
      tick();
      chk("bp rel sp_rden", 64'(sp_rden), 64'h1);
      chk("bp rel rr_rden", 64'(rr_rden), 64'h8);

      // Timeout: no md, pulse lands 15 cycles after the grant edge.
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("to early", 64'({sp_to, rr_to, sp_wr}), 64'h0);
      end
      tick();
      chk("to sp pulse", 64'(sp_to), 64'h1);
      chk("to rr pulse", 64'(rr_to), 64'h1);
      chk("to no wr", 64'({sp_wr, rr_wr}), 64'h0);
      tick();
      chk("to one shot", 64'({sp_to, rr_to}), 64'h0);
      chk("to next sp_rden", 64'(sp_rden), 64'h1);
      chk("to next rr_rden", 64'(rr_rden), 64'h1);

      // md_wr in the expiry cycle wins.
      for (int i = 0; i < 14; i++) tick();
      md_wr = 1'b1; md_in = 8'hC3;
      tick();
      md_wr = 1'b0; md_in = '0;
      chk("exp sp_wr", 64'(sp_wr), 64'h1);
      chk("exp sp_md", 64'(sp_md), 64'hC3);
      chk("exp rr_qid", 64'(rr_qid), 64'h0);
      chk("exp no to", 64'({sp_to, rr_to}), 64'h0);
`ifdef TS_SCHED_STAT_EN
      chk("sp tocnt", 64'(sp_tocnt), 64'h1);
      chk("rr stat q0", 64'(rr_stat[15:0]), 64'h3);
`endif
      tick();
      chk("exp after no to", 64'({sp_to, rr_to}), 64'h0);
      chk("exp next sp_rden", 64'(sp_rden), 64'h1);
      chk("exp next rr_rden", 64'(rr_rden), 64'h2);

      // Reset while the read is outstanding; late md must be dropped.
      gate = 4'b0000;
      rst_n = 1'b0;
      #1;
      chk_idle_outs("mid rst");
      tick();
      rst_n = 1'b1;
      md_wr = 1'b1; md_in = 8'hEE;
      tick();
      md_wr = 1'b0; md_in = '0;
      chk_idle_outs("post rst");
`ifdef TS_SCHED_STAT_EN
      chk("rst sp stat", 64'(sp_stat), 64'h0);
      chk("rst rr stat", 64'(rr_stat), 64'h0);
      chk("rst tocnt", 64'({sp_tocnt, rr_tocnt}), 64'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
